// File: rtl/player_bullet.sv
// ---------------------------------------------------------------------------
// player_bullet
//   Player projectile source. A fire request launches a single upward
//   bullet from the ship. The bullet moves once per frame. It publishes an
//   active flag and a bounding box for the alien collision controllers. It
//   retires on the OR-reduced alien hit or when it leaves the top of the
//   screen. It also renders its own pixel into the video mix.
//
//   Optional feature macro: PLAYER_AUTOFIRE_EN
//     defined   - fire held high requests a launch at every fsync in IDLE
//     undefined - only rising edges of fire request a launch
//
// Ports
//   pixel_clk      in   pixel clock (single clock domain)
//   rst            in   synchronous active-high reset
//   fsync          in   one-cycle frame strobe
//   hpos, vpos     in   current raster position (signed 12)
//   fire           in   fire button level
//   ship_x, ship_y in   ship horizontal centre / top edge (signed 12)
//   alien_hit      in   OR of all alien hit flags
//   bullet_active  out  bullet in flight
//   bullet_left    out  box left, inclusive
//   bullet_right   out  box right, exclusive
//   bullet_top     out  box top, inclusive
//   bullet_bottom  out  box bottom, exclusive
//   pixel[0:2]     out  registered colour, index 0 blue, 1 green, 2 red
//   active         out  registered "raster inside drawn bullet"
//   hit_count      out  saturating count of confirmed hits
// ---------------------------------------------------------------------------
module player_bullet #(
   parameter int          BULLET_W        = 4,
   parameter int          BULLET_H        = 12,
   parameter int          BULLET_SPEED    = 8,
   parameter int          COOLDOWN_FRAMES = 15,
   parameter logic [23:0] BULLET_COLOR    = 24'hFFFF00
) (
   input  logic               pixel_clk,
   input  logic               rst,
   input  logic               fsync,
   input  logic signed [11:0] hpos,
   input  logic signed [11:0] vpos,
   input  logic               fire,
   input  logic signed [11:0] ship_x,
   input  logic signed [11:0] ship_y,
   input  logic               alien_hit,
   output logic               bullet_active,
   output logic signed [11:0] bullet_left,
   output logic signed [11:0] bullet_right,
   output logic signed [11:0] bullet_top,
   output logic signed [11:0] bullet_bottom,
   output logic [7:0]         pixel [0:2],
   output logic               active,
   output logic [7:0]         hit_count
);

   localparam logic signed [11:0] W12      = 12'(BULLET_W);
   localparam logic signed [11:0] HALF_W12 = 12'(BULLET_W / 2);
   localparam logic signed [11:0] H12      = 12'(BULLET_H);
   localparam logic signed [11:0] SPEED12  = 12'(BULLET_SPEED);
   localparam logic [7:0]         COOL8    = 8'(COOLDOWN_FRAMES);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLYING   = 2'd1,
      COOLDOWN = 2'd2
   } state_e;

   state_e             state_q;
   logic signed [11:0] bx_q;
   logic signed [11:0] by_q;
   logic [7:0]         cool_q;
   logic               fire_prev_q;
   logic               fire_req_q;
   logic               fire_req_d;
   logic               bullet_active_q;
   logic [7:0]         hits_q;
   logic [7:0]         pix_q [0:2];
   logic               active_q;

   logic               fire_edge_s;
   logic               launch_req_s;
   logic signed [11:0] ny_d;
   logic signed [11:0] ny_bottom_s;
   logic               exit_top_s;
   logic               in_box_s;

   // Request decode, next-frame position and raster hit test
   always_comb begin
      fire_edge_s = fire & ~fire_prev_q;
`ifdef PLAYER_AUTOFIRE_EN
      launch_req_s = fire_req_q | fire_edge_s | fire;
`else
      launch_req_s = fire_req_q | fire_edge_s;
`endif
      // A request lives for at most one frame: every fsync drops it
      if (fsync) begin
         fire_req_d = 1'b0;
      end else if (fire_edge_s) begin
         fire_req_d = 1'b1;
      end else begin
         fire_req_d = fire_req_q;
      end
      ny_d        = by_q - SPEED12;
      ny_bottom_s = ny_d + H12;
      exit_top_s  = (ny_bottom_s <= 12'sd0);
      in_box_s    = bullet_active_q &&
                    (hpos >= bx_q) && (hpos < bx_q + W12) &&
                    (vpos >= by_q) && (vpos < by_q + H12);
   end

   // Fire edge detector and one-frame request latch
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         fire_prev_q <= 1'b0;
         fire_req_q  <= 1'b0;
      end else begin
         fire_prev_q <= fire;
         fire_req_q  <= fire_req_d;
      end
   end

   // Bullet FSM: launch, per-frame motion, hit/exit retirement, cooldown
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         state_q         <= IDLE;
         bx_q            <= 12'sd0;
         by_q            <= 12'sd0;
         cool_q          <= 8'd0;
         bullet_active_q <= 1'b0;
         hits_q          <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fsync && launch_req_s) begin
                  bx_q            <= ship_x - HALF_W12;
                  by_q            <= ship_y - H12;
                  bullet_active_q <= 1'b1;
                  state_q         <= FLYING;
               end
            end
            FLYING: begin
               // A hit wins over a same-cycle fsync; position stays put
               if (alien_hit) begin
                  bullet_active_q <= 1'b0;
                  hits_q          <= (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
                  cool_q          <= COOL8;
                  state_q         <= COOLDOWN;
               end else if (fsync) begin
                  if (exit_top_s) begin
                     bullet_active_q <= 1'b0;
                     cool_q          <= COOL8;
                     state_q         <= COOLDOWN;
                  end else begin
                     by_q <= ny_d;
                  end
               end
            end
            COOLDOWN: begin
               // The fsync that finds zero only returns to IDLE; it cannot launch
               if (fsync) begin
                  if (cool_q == 8'd0) begin
                     state_q <= IDLE;
                  end else begin
                     cool_q <= cool_q - 8'd1;
                  end
               end
            end
            default: begin
               bullet_active_q <= 1'b0;
               state_q         <= IDLE;
            end
         endcase
      end
   end

   // Registered pixel output, one cycle behind hpos/vpos
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         pix_q[0] <= 8'd0;
         pix_q[1] <= 8'd0;
         pix_q[2] <= 8'd0;
         active_q <= 1'b0;
      end else if (in_box_s) begin
         pix_q[0] <= BULLET_COLOR[7:0];
         pix_q[1] <= BULLET_COLOR[15:8];
         pix_q[2] <= BULLET_COLOR[23:16];
         active_q <= 1'b1;
      end else begin
         pix_q[0] <= 8'd0;
         pix_q[1] <= 8'd0;
         pix_q[2] <= 8'd0;
         active_q <= 1'b0;
      end
   end

   assign bullet_active = bullet_active_q;
   assign bullet_left   = bx_q;
   assign bullet_right  = bx_q + W12;
   assign bullet_top    = by_q;
   assign bullet_bottom = by_q + H12;
   assign pixel[0]      = pix_q[0];
   assign pixel[1]      = pix_q[1];
   assign pixel[2]      = pix_q[2];
   assign active        = active_q;
   assign hit_count     = hits_q;

endmodule
